branch_predictor_gshare: RTL

//  Parametrised gshare branch predictor with direct-mapped BTB, sitting beside fetch_Cycle.

---
 rtl/branch_predictor_gshare_pkg.sv | 23 ++
 rtl/branch_predictor_gshare_if.sv | 38 +++
 rtl/branch_predictor_gshare_sat_counter_array.sv | 43 ++++
 rtl/branch_predictor_gshare.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types for the gshare predictor: control-flow kinds, BTB entry metadata
// and the PHT counter reset value (weak not-taken).
package bp_pkg;

  typedef enum logic [1:0] {
    BP_COND = 2'd0,
    BP_CALL = 2'd1,
    BP_RET  = 2'd2,
    BP_RSVD = 2'd3
  } bp_type_e;

  // Tag and target widths depend on top-level parameters, so they live in
  // parallel arrays next to this per-entry metadata.
  typedef struct packed {
    logic     valid;
    bp_type_e btype;
  } btb_entry_t;

  function automatic int ctr_reset_val(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch lookup / execute resolve bundle between the pipeline (master) and the
// branch predictor (slave).
interface branch_predictor_gshare_if #(
  parameter int PC_W      = 5,
  parameter int GHR_W     = 4,
  parameter int RAS_PTR_W = 2
) ();

  logic                 f_valid;
  logic [PC_W-1:0]      f_pc;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [PC_W-1:0]      pred_target;
  logic [GHR_W-1:0]     pred_ghr;
  logic [RAS_PTR_W-1:0] pred_ras_ptr;

  logic                 u_valid;
  logic [PC_W-1:0]      u_pc;
  logic [1:0]           u_type;
  logic                 u_taken;
  logic [PC_W-1:0]      u_target;
  logic [GHR_W-1:0]     u_ghr;
  logic [RAS_PTR_W-1:0] u_ras_ptr;
  logic                 u_mispredict;

  modport master (
    output f_valid, f_pc,
    output u_valid, u_pc, u_type, u_taken, u_target, u_ghr, u_ras_ptr, u_mispredict,
    input  pred_hit, pred_taken, pred_target, pred_ghr, pred_ras_ptr
  );

  modport slave (
    input  f_valid, f_pc,
    input  u_valid, u_pc, u_type, u_taken, u_target, u_ghr, u_ras_ptr, u_mispredict,
    output pred_hit, pred_taken, pred_target, pred_ghr, pred_ras_ptr
  );

endinterface

// File: rtl/branch_predictor_gshare_sat_counter_array.sv
// Pattern history table: 2**IDX_W saturating counters with one combinational
// read port (direction bit only) and one clocked +/-1 update port.
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_inc_i
);

  localparam int             N       = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] ctr_q [N];
  logic [CTR_W-1:0] wr_cur, ctr_d;

  assign rd_taken_o = ctr_q[rd_idx_i][CTR_W-1];
  assign wr_cur     = ctr_q[wr_idx_i];

  // Saturate at both ends rather than wrapping.
  always_comb begin
    ctr_d = wr_cur;
    if (wr_inc_i && wr_cur != CTR_MAX)      ctr_d = wr_cur + CTR_W'(1);
    else if (!wr_inc_i && wr_cur != '0)     ctr_d = wr_cur - CTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RST;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare predictor with direct-mapped BTB and speculative GHR repaired on mispredict.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int GHR_W     = 4,
  parameter int PHT_IDX_W = 4,
  parameter int CTR_W     = 2,
  parameter int BTB_IDX_W = 3,
  parameter int RAS_DEPTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  branch_predictor_gshare_if.slave bp
);

  localparam int BTB_N     = 1 << BTB_IDX_W;
  localparam int TAG_W     = PC_W - BTB_IDX_W;
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  // History is zero-extended or truncated to the PHT index width.
  function automatic logic [PHT_IDX_W-1:0] fold(input logic [GHR_W-1:0] h);
    return PHT_IDX_W'(h);
  endfunction

  btb_entry_t       btb_meta_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_q  [BTB_N];
  logic [PC_W-1:0]  btb_tgt_q  [BTB_N];

  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [PHT_IDX_W-1:0] f_pht_idx, u_pht_idx;
  btb_entry_t           f_ent;
  bp_type_e             u_type;
  logic                 hit, taken, pht_taken;
  logic                 fetch_hit, u_known, btb_we, pht_we, repair;
  logic [PC_W-1:0]      btb_target, ras_target;

  assign f_btb_idx = bp.f_pc[BTB_IDX_W-1:0];
  assign f_tag     = bp.f_pc[PC_W-1:BTB_IDX_W];
  assign u_btb_idx = bp.u_pc[BTB_IDX_W-1:0];
  assign u_tag     = bp.u_pc[PC_W-1:BTB_IDX_W];
  assign f_pht_idx = PHT_IDX_W'(bp.f_pc) ^ fold(ghr_q);
  assign u_pht_idx = PHT_IDX_W'(bp.u_pc) ^ fold(bp.u_ghr);

  assign f_ent      = btb_meta_q[f_btb_idx];
  assign btb_target = btb_tgt_q[f_btb_idx];
  assign hit        = f_ent.valid && (btb_tag_q[f_btb_idx] == f_tag);
  assign taken      = hit && (f_ent.btype != BP_COND || pht_taken);
  assign fetch_hit  = bp.f_valid && hit;

  // Reserved resolve type is dropped entirely: no training, no repair.
  assign u_type  = bp_type_e'(bp.u_type);
  assign u_known = bp.u_valid && u_type != BP_RSVD;
  assign btb_we  = u_known && bp.u_taken;
  assign pht_we  = bp.u_valid && u_type == BP_COND;
  assign repair  = u_known && bp.u_mispredict;

  bp_sat_counter_array #(
    .IDX_W (PHT_IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (f_pht_idx),
    .rd_taken_o (pht_taken),
    .wr_en_i    (pht_we),
    .wr_idx_i   (u_pht_idx),
    .wr_inc_i   (bp.u_taken)
  );

  // Repair is applied last so it overrides a same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (fetch_hit && f_ent.btype == BP_COND) ghr_d = {ghr_q[GHR_W-2:0], taken};
    if (repair) ghr_d = (u_type == BP_COND) ? {bp.u_ghr[GHR_W-2:0], bp.u_taken} : bp.u_ghr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_meta_q[i] <= '{valid: 1'b0, btype: BP_COND};
        btb_tag_q[i]  <= '0;
        btb_tgt_q[i]  <= '0;
      end
    end else if (btb_we) begin
      btb_meta_q[u_btb_idx] <= '{valid: 1'b1, btype: u_type};
      btb_tag_q[u_btb_idx]  <= u_tag;
      btb_tgt_q[u_btb_idx]  <= bp.u_target;
    end
  end

`ifdef BP_RAS_EN
  // Circular stack: ras_ptr_q is the next free slot, top is ras_ptr_q-1.
  logic [PC_W-1:0]      ras_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d, ras_top_idx;
  logic                 ras_push, ras_pop;

  assign ras_top_idx = ras_ptr_q - RAS_PTR_W'(1);
  assign ras_target  = ras_q[ras_top_idx];
  assign ras_push    = fetch_hit && f_ent.btype == BP_CALL;
  assign ras_pop     = fetch_hit && f_ent.btype == BP_RET;

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    if (ras_push)     ras_ptr_d = ras_ptr_q + RAS_PTR_W'(1);
    else if (ras_pop) ras_ptr_d = ras_ptr_q - RAS_PTR_W'(1);
    if (repair) begin
      case (u_type)
        BP_CALL: ras_ptr_d = bp.u_ras_ptr + RAS_PTR_W'(1);
        BP_RET:  ras_ptr_d = bp.u_ras_ptr - RAS_PTR_W'(1);
        default: ras_ptr_d = bp.u_ras_ptr;
      endcase
    end
  end

  // A repaired call also rewrites its return address, since the wrong path may have clobbered it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      if (ras_push) ras_q[ras_ptr_q] <= bp.f_pc + PC_W'(1);
      if (repair && u_type == BP_CALL) ras_q[bp.u_ras_ptr] <= bp.u_pc + PC_W'(1);
    end
  end

  assign bp.pred_ras_ptr = ras_ptr_q;
`else
  logic unused_ras;
  assign unused_ras      = ^bp.u_ras_ptr;
  assign ras_target      = btb_target;
  assign bp.pred_ras_ptr = '0;
`endif

  assign bp.pred_hit    = hit;
  assign bp.pred_taken  = taken;
  assign bp.pred_target = !hit ? '0 : (f_ent.btype == BP_RET) ? ras_target : btb_target;
  assign bp.pred_ghr    = ghr_q;

endmodule
